// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the unified instruction/data RAM arbiter.
// Owner encoding tags the pending read response; defaults size the address and starvation bound.
package mem_arbiter_pkg;

    localparam int DATA_MEM_ADDR_SIZE = 10;
    localparam int STARVE_MAX_DEFAULT = 3;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_MEM  = 2'd2
    } owner_e;

    // Counter width able to hold 0..max (at least one bit so a disabled bound still elaborates).
    function automatic int starve_w(input int max);
        return (max > 1) ? $clog2(max + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// Counts consecutive cycles in which a fetch request was denied and raises
// force_if once the count reaches STARVE_MAX, guaranteeing fetch progress.
module mem_arbiter_starve_cnt
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_grant,
    output logic force_if
);

    localparam int            SW      = starve_w(STARVE_MAX);
    localparam logic [SW-1:0] CNT_MAX = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt_q;
    logic [SW-1:0] starve_cnt_d;

    always_comb begin
        starve_cnt_d = '0;
        if (!rst && if_req && !if_grant) begin
            starve_cnt_d = (starve_cnt_q == CNT_MAX) ? CNT_MAX : starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // With STARVE_MAX == 0 the count is pinned at zero and forcing never happens.
    assign force_if = (STARVE_MAX != 0) && (starve_cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read RAM between instruction fetch and the MEM-stage
// load/store port: MEM wins by default, fetch is force-granted after bounded starvation.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DATA_MEM_ADDR_SIZE,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic              ifStall,
    output logic              ifValid,
    output logic [31:0]       ifRData,
    input  logic              memRd,
    input  logic              memWr,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [31:0]       memWData,
    output logic              memStall,
    output logic              memValid,
    output logic [31:0]       memRData,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [31:0]       ramData,
    output logic              ramWren,
    output logic              ramRden,
    input  logic [31:0]       ramQ,
    output logic [CNT_W-1:0]  conflictCount
);

    logic             mem_req;
    logic             grant_if;
    logic             grant_mem;
    logic             force_if;
    logic             if_valid;
    logic             mem_valid;
    owner_e           resp_owner_q;
    owner_e           resp_owner_d;
    logic [31:0]      if_hold_q;
    logic [31:0]      if_hold_d;
    logic [31:0]      mem_hold_q;
    logic [31:0]      mem_hold_d;
    logic [CNT_W-1:0] conflict_cnt_q;
    logic [CNT_W-1:0] conflict_cnt_d;

    mem_arbiter_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .if_req   (ifReq),
        .if_grant (grant_if),
        .force_if (force_if)
    );

    // Nothing is granted while in reset, so stalls and RAM strobes all read 0.
    always_comb begin
        mem_req   = memRd | memWr;
        grant_if  = ~rst & ifReq & (force_if | ~mem_req);
        grant_mem = ~rst & mem_req & ~grant_if;
        ifStall   = ~rst & ifReq & ~grant_if;
        memStall  = ~rst & mem_req & ~grant_mem;
    end

    always_comb begin
        ramAddr = '0;
        ramData = '0;
        ramWren = 1'b0;
        ramRden = 1'b0;
        if (grant_if) begin
            ramAddr = ifAddr;
            ramRden = 1'b1;
        end else if (grant_mem) begin
            ramAddr = memAddr;
            // A simultaneous read and write is handled as a plain write.
            ramWren = memWr;
            ramRden = ~memWr;
            ramData = memWr ? memWData : 32'd0;
        end
    end

    always_comb begin
        resp_owner_d = OWNER_NONE;
        if (grant_if) begin
            resp_owner_d = OWNER_IF;
        end else if (grant_mem && !memWr) begin
            resp_owner_d = OWNER_MEM;
        end
    end

    always_comb begin
        if_valid   = ~rst & (resp_owner_q == OWNER_IF);
        mem_valid  = ~rst & (resp_owner_q == OWNER_MEM);
        if_hold_d  = rst ? 32'd0 : (if_valid ? ramQ : if_hold_q);
        mem_hold_d = rst ? 32'd0 : (mem_valid ? ramQ : mem_hold_q);
        ifValid    = if_valid;
        memValid   = mem_valid;
        ifRData    = if_valid ? ramQ : if_hold_q;
        memRData   = mem_valid ? ramQ : mem_hold_q;
    end

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (rst) begin
            conflict_cnt_d = '0;
        end else if (ifReq && mem_req && (conflict_cnt_q != {CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    assign conflictCount = conflict_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_owner_q   <= OWNER_NONE;
            if_hold_q      <= '0;
            mem_hold_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            resp_owner_q   <= resp_owner_d;
            if_hold_q      <= if_hold_d;
            mem_hold_q     <= mem_hold_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a registered-read RAM model sits on the RAM port,
// each scenario task drives inputs at the falling edge and checks 1 time unit later.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifReq;
    logic [7:0]  ifAddr;
    logic        ifStall;
    logic        ifValid;
    logic [31:0] ifRData;
    logic        memRd;
    logic        memWr;
    logic [7:0]  memAddr;
    logic [31:0] memWData;
    logic        memStall;
    logic        memValid;
    logic [31:0] memRData;
    logic [7:0]  ramAddr;
    logic [31:0] ramData;
    logic        ramWren;
    logic        ramRden;
    logic [31:0] ramQ;
    logic [3:0]  conflictCount;

    int n_vec;
    int n_err;

    logic [31:0] ram [256];

    mem_arbiter #(
        .ADDR_W     (8),
        .STARVE_MAX (3),
        .CNT_W      (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifReq         (ifReq),
        .ifAddr        (ifAddr),
        .ifStall       (ifStall),
        .ifValid       (ifValid),
        .ifRData       (ifRData),
        .memRd         (memRd),
        .memWr         (memWr),
        .memAddr       (memAddr),
        .memWData      (memWData),
        .memStall      (memStall),
        .memValid      (memValid),
        .memRData      (memRData),
        .ramAddr       (ramAddr),
        .ramData       (ramData),
        .ramWren       (ramWren),
        .ramRden       (ramRden),
        .ramQ          (ramQ),
        .conflictCount (conflictCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ramWren) ram[ramAddr] <= ramData;
        if (ramRden) ramQ <= ram[ramAddr];
    end

    task automatic set_idle();
        ifReq    = 1'b0;
        ifAddr   = 8'd0;
        memRd    = 1'b0;
        memWr    = 1'b0;
        memAddr  = 8'd0;
        memWData = 32'd0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; ifReq = 1'b1; ifAddr = 8'd5; memRd = 1'b1; memAddr = 8'd9;
        #1;
        n_vec++; if (ifStall !== 1'b0) begin n_err++; $display("FAIL reset_ifStall got=%0h want=0", ifStall); end
        n_vec++; if (memStall !== 1'b0) begin n_err++; $display("FAIL reset_memStall got=%0h want=0", memStall); end
        n_vec++; if ({ramRden, ramWren} !== 2'b00) begin n_err++; $display("FAIL reset_ram_strobes got=%b want=00", {ramRden, ramWren}); end
        @(negedge clk);
        rst = 1'b0; set_idle();
        #1;
        n_vec++; if ({ifValid, memValid} !== 2'b00) begin n_err++; $display("FAIL post_reset_valid got=%b want=00", {ifValid, memValid}); end
        n_vec++; if (ifRData !== 32'd0 || memRData !== 32'd0) begin n_err++; $display("FAIL post_reset_rdata got=%h/%h want=0/0", ifRData, memRData); end
        n_vec++; if (conflictCount !== 4'd0) begin n_err++; $display("FAIL post_reset_conflict got=%0d want=0", conflictCount); end
        n_vec++; if (ramAddr !== 8'd0 || ramData !== 32'd0) begin n_err++; $display("FAIL idle_ram_bus got=%h/%h want=0/0", ramAddr, ramData); end
    endtask

    task automatic test_store_load();
        @(negedge clk);
        memWr = 1'b1; memAddr = 8'd5; memWData = 32'hDEADBEEF;
        #1;
        n_vec++; if ({ramWren, ramRden, memStall} !== 3'b100) begin n_err++; $display("FAIL store5_strobes got=%b want=100", {ramWren, ramRden, memStall}); end
        n_vec++; if (ramAddr !== 8'd5 || ramData !== 32'hDEADBEEF) begin n_err++; $display("FAIL store5_bus got=%h/%h want=05/deadbeef", ramAddr, ramData); end
        @(negedge clk);
        memAddr = 8'd9; memWData = 32'h12;
        #1;
        n_vec++; if (memValid !== 1'b0) begin n_err++; $display("FAIL store_no_resp got=%0h want=0", memValid); end
        @(negedge clk);
        memAddr = 8'd3; memWData = 32'hA5A5A5A5;
        #1;
        n_vec++; if (ramWren !== 1'b1 || ramAddr !== 8'd3) begin n_err++; $display("FAIL store3 got=%0h/%h want=1/03", ramWren, ramAddr); end
        @(negedge clk);
        memWr = 1'b0; memRd = 1'b1; memAddr = 8'd3;
        #1;
        n_vec++; if ({ramRden, ramWren} !== 2'b10) begin n_err++; $display("FAIL load3_strobes got=%b want=10", {ramRden, ramWren}); end
        @(negedge clk);
        set_idle();
        #1;
        n_vec++; if (memValid !== 1'b1 || memRData !== 32'hA5A5A5A5) begin n_err++; $display("FAIL load3_data got=%0h/%h want=1/a5a5a5a5", memValid, memRData); end
        @(negedge clk);
        #1;
        n_vec++; if (memValid !== 1'b0 || memRData !== 32'hA5A5A5A5) begin n_err++; $display("FAIL load3_hold got=%0h/%h want=0/a5a5a5a5", memValid, memRData); end
    endtask

    task automatic test_rd_wr_both();
        @(negedge clk);
        memRd = 1'b1; memWr = 1'b1; memAddr = 8'd7; memWData = 32'h77;
        #1;
        n_vec++; if ({ramWren, ramRden} !== 2'b10 || ramData !== 32'h77) begin n_err++; $display("FAIL rdwr_as_write got=%b/%h want=10/77", {ramWren, ramRden}, ramData); end
        @(negedge clk);
        memWr = 1'b0; memRd = 1'b1; memAddr = 8'd7;
        #1;
        n_vec++; if (memValid !== 1'b0) begin n_err++; $display("FAIL rdwr_no_valid got=%0h want=0", memValid); end
        @(negedge clk);
        set_idle();
        #1;
        n_vec++; if (memValid !== 1'b1 || memRData !== 32'h77) begin n_err++; $display("FAIL rdwr_readback got=%0h/%h want=1/77", memValid, memRData); end
    endtask

    task automatic test_if_read();
        @(negedge clk);
        ifReq = 1'b1; ifAddr = 8'd5;
        #1;
        n_vec++; if (ifStall !== 1'b0 || ramRden !== 1'b1 || ramAddr !== 8'd5) begin n_err++; $display("FAIL if_grant got=%0h/%0h/%h want=0/1/05", ifStall, ramRden, ramAddr); end
        @(negedge clk);
        set_idle();
        #1;
        n_vec++; if (ifValid !== 1'b1 || ifRData !== 32'hDEADBEEF || memValid !== 1'b0) begin n_err++; $display("FAIL if_data got=%0h/%h/%0h want=1/deadbeef/0", ifValid, ifRData, memValid); end
        @(negedge clk);
        #1;
        n_vec++; if (ifValid !== 1'b0 || ifRData !== 32'hDEADBEEF) begin n_err++; $display("FAIL if_hold got=%0h/%h want=0/deadbeef", ifValid, ifRData); end
    endtask

    task automatic test_conflict();
        @(negedge clk);
        ifReq = 1'b1; ifAddr = 8'd5; memRd = 1'b1; memAddr = 8'd9;
        #1;
        n_vec++; if ({ifStall, memStall} !== 2'b10 || ramAddr !== 8'd9) begin n_err++; $display("FAIL conflict_grant got=%b/%h want=10/09", {ifStall, memStall}, ramAddr); end
        @(negedge clk);
        set_idle();
        #1;
        n_vec++; if (memValid !== 1'b1 || memRData !== 32'h12 || ifValid !== 1'b0) begin n_err++; $display("FAIL conflict_data got=%0h/%h/%0h want=1/12/0", memValid, memRData, ifValid); end
        n_vec++; if (conflictCount !== 4'd1) begin n_err++; $display("FAIL conflict_count got=%0d want=1", conflictCount); end
    endtask

    task automatic test_starvation();
        logic exp_if_stall;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ifReq = 1'b1; ifAddr = 8'd5; memRd = 1'b1; memAddr = 8'd9;
            #1;
            exp_if_stall = (i != 3);
            n_vec++;
            if (ifStall !== exp_if_stall || memStall !== ~exp_if_stall) begin
                n_err++; $display("FAIL starve_cycle%0d got=%0h/%0h want=%0h/%0h", i, ifStall, memStall, exp_if_stall, ~exp_if_stall);
            end
            if (i == 1) begin
                n_vec++; if (memValid !== 1'b1 || memRData !== 32'h12) begin n_err++; $display("FAIL starve_mem_data got=%0h/%h want=1/12", memValid, memRData); end
            end
            if (i == 4) begin
                n_vec++; if (ifValid !== 1'b1 || ifRData !== 32'hDEADBEEF || memValid !== 1'b0) begin n_err++; $display("FAIL starve_if_data got=%0h/%h/%0h want=1/deadbeef/0", ifValid, ifRData, memValid); end
            end
        end
        @(negedge clk);
        set_idle();
        #1;
        n_vec++; if (conflictCount !== 4'd7) begin n_err++; $display("FAIL starve_conflicts got=%0d want=7", conflictCount); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        ifReq = 1'b1; ifAddr = 8'd5;
        @(negedge clk);
        ifReq = 1'b0; memRd = 1'b1; memAddr = 8'd3;
        #1;
        n_vec++; if (ifValid !== 1'b1 || ifRData !== 32'hDEADBEEF || ramRden !== 1'b1) begin n_err++; $display("FAIL b2b_if got=%0h/%h/%0h want=1/deadbeef/1", ifValid, ifRData, ramRden); end
        @(negedge clk);
        memRd = 1'b0; ifReq = 1'b1; ifAddr = 8'd9;
        #1;
        n_vec++; if (memValid !== 1'b1 || memRData !== 32'hA5A5A5A5 || ifValid !== 1'b0) begin n_err++; $display("FAIL b2b_mem got=%0h/%h/%0h want=1/a5a5a5a5/0", memValid, memRData, ifValid); end
        @(negedge clk);
        set_idle();
        #1;
        n_vec++; if (ifValid !== 1'b1 || ifRData !== 32'h12 || memValid !== 1'b0 || memRData !== 32'hA5A5A5A5) begin
            n_err++; $display("FAIL b2b_if2 got=%0h/%h/%0h/%h want=1/12/0/a5a5a5a5", ifValid, ifRData, memValid, memRData);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        ifReq = 1'b1; ifAddr = 8'd3;
        @(negedge clk);
        set_idle(); rst = 1'b1;
        #1;
        n_vec++; if (ifValid !== 1'b0 || ramRden !== 1'b0) begin n_err++; $display("FAIL midrst_n1 got=%0h/%0h want=0/0", ifValid, ramRden); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++; if (ifValid !== 1'b0 || ifRData !== 32'd0 || memRData !== 32'd0) begin n_err++; $display("FAIL midrst_n2 got=%0h/%h/%h want=0/0/0", ifValid, ifRData, memRData); end
        n_vec++; if (conflictCount !== 4'd0) begin n_err++; $display("FAIL midrst_conflict got=%0d want=0", conflictCount); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ifReq = 1'b1; ifAddr = 8'd5; memRd = 1'b1; memAddr = 8'd9;
            #1;
            if (i == 10) begin
                n_vec++; if (conflictCount !== 4'd10) begin n_err++; $display("FAIL sat_mid got=%0d want=10", conflictCount); end
            end
        end
        @(negedge clk);
        set_idle();
        #1;
        n_vec++; if (conflictCount !== 4'hF) begin n_err++; $display("FAIL sat_final got=%0d want=15", conflictCount); end
        @(negedge clk);
        #1;
        n_vec++; if (conflictCount !== 4'hF) begin n_err++; $display("FAIL sat_hold got=%0d want=15", conflictCount); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        set_idle();
        test_reset();
        test_store_load();
        test_rd_wr_both();
        test_if_read();
        test_conflict();
        test_starvation();
        test_back_to_back();
        test_reset_mid_read();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
